// File: rtl/plic_gateway.sv
// plic_gateway
//   Interrupt gateway between raw device interrupt lines and a PLIC core.
//   Each source is synchronized, converted to a request (level or edge
//   mode, chosen per source by EDGE_MASK) and tracked by a small
//   IDLE/PEND/CLAIMED state machine. Edge-mode sources keep a saturating
//   count of edges seen while a request is already outstanding, so those
//   edges are replayed as fresh requests on later completes.
//
// Ports
//   CLK            in   sole clock, rising edge
//   RST            in   synchronous active-high reset
//   w_irq          in   raw interrupt lines (asynchronous to CLK)
//   w_claim        in   one-cycle claim strobe
//   w_claim_id     in   ID being claimed
//   w_complete     in   one-cycle complete strobe
//   w_complete_id  in   ID being completed
//   w_pending      out  sources in PEND (bit 0 always 0)
//   w_inflight     out  sources in CLAIMED
//   w_overflow     out  one-cycle pulse when a saturated edge counter sees another edge
module plic_gateway #(
  parameter int                   N_INT_SRC  = 32,
  parameter logic [N_INT_SRC-1:0] EDGE_MASK  = '0,
  parameter int                   W_EDGE_CNT = 3,
  localparam int                  W_ID       = $clog2(N_INT_SRC)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_INT_SRC-1:0] w_irq,
  input  logic                 w_claim,
  input  logic [W_ID-1:0]      w_claim_id,
  input  logic                 w_complete,
  input  logic [W_ID-1:0]      w_complete_id,
  output logic [N_INT_SRC-1:0] w_pending,
  output logic [N_INT_SRC-1:0] w_inflight,
  output logic                 w_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    CLAIMED = 2'd2
  } state_e;

  localparam logic [W_EDGE_CNT-1:0] CNT_MAX = '1;

  logic [N_INT_SRC-1:0]  sync1_q;
  logic [N_INT_SRC-1:0]  sync2_q;
  logic [N_INT_SRC-1:0]  sync3_q;
  logic [N_INT_SRC-1:0]  edgeEvt_q;
  logic [N_INT_SRC-1:0]  ovf_d;
  logic                  overflow_q;
  state_e                state_q [N_INT_SRC];
  state_e                state_d [N_INT_SRC];
  logic [W_EDGE_CNT-1:0] cnt_q   [N_INT_SRC];
  logic [W_EDGE_CNT-1:0] cnt_d   [N_INT_SRC];

  // Per-source next-state logic. The level request is the third flop
  // (sync3_q) and the edge request is registered from sync2 vs sync3, so
  // both reach the FSM in the same cycle and a line rise shows up in
  // w_pending three edges after it is first sampled.
  // For edge sources, an edge seen while a request is outstanding is
  // counted first, and the complete decision looks at the updated count;
  // this lets an edge arriving together with a complete re-pend the source.
  always_comb begin
    for (int i = 0; i < N_INT_SRC; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = 1'b0;

      if (EDGE_MASK[i] && edgeEvt_q[i] && (state_q[i] != IDLE)) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      case (state_q[i])
        IDLE: begin
          if (EDGE_MASK[i] ? edgeEvt_q[i] : sync3_q[i]) begin
            state_d[i] = PEND;
          end
        end
        PEND: begin
          if (w_claim && (w_claim_id == W_ID'(i))) begin
            state_d[i] = CLAIMED;
          end
        end
        CLAIMED: begin
          if (w_complete && (w_complete_id == W_ID'(i))) begin
            if (cnt_d[i] != '0) begin
              state_d[i] = PEND;
              cnt_d[i]   = cnt_d[i] - 1'b1;
            end else begin
              state_d[i] = IDLE;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase

      // ID 0 is reserved: that source never leaves IDLE
      if (i == 0) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        ovf_d[i]   = 1'b0;
      end
    end
  end

  // Synchronizer chain, edge-event register, FSM state and edge counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      edgeEvt_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < N_INT_SRC; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q    <= w_irq;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      edgeEvt_q  <= sync2_q & ~sync3_q;
      overflow_q <= |ovf_d;
      for (int i = 0; i < N_INT_SRC; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Status vectors decoded straight from the state registers
  always_comb begin
    w_pending  = '0;
    w_inflight = '0;
    for (int i = 1; i < N_INT_SRC; i++) begin
      w_pending[i]  = (state_q[i] == PEND);
      w_inflight[i] = (state_q[i] == CLAIMED);
    end
  end

  assign w_overflow = overflow_q;

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway
//   Directed bench for plic_gateway with 32 sources, source 3 edge-triggered
//   and a 3-bit edge counter. Every other source is level-triggered.
module tb_plic_gateway;

  logic        CLK;
  logic        RST;
  logic [31:0] w_irq;
  logic        w_claim;
  logic [4:0]  w_claim_id;
  logic        w_complete;
  logic [4:0]  w_complete_id;
  logic [31:0] w_pending;
  logic [31:0] w_inflight;
  logic        w_overflow;

  int testsRun    = 0;
  int testsFailed = 0;
  int ovfPulses   = 0;

  plic_gateway #(
    .N_INT_SRC (32),
    .EDGE_MASK (32'h0000_0008),
    .W_EDGE_CNT(3)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_irq        (w_irq),
    .w_claim      (w_claim),
    .w_claim_id   (w_claim_id),
    .w_complete   (w_complete),
    .w_complete_id(w_complete_id),
    .w_pending    (w_pending),
    .w_inflight   (w_inflight),
    .w_overflow   (w_overflow)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count every cycle in which the overflow pulse is high
  always @(negedge CLK) begin
    if (w_overflow === 1'b1) ovfPulses++;
  end

  // Advance n rising edges and land 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Drive claim/complete strobes for exactly one rising edge
  task automatic applyStimulus(input logic clm, input logic [4:0] clmId, input logic cmp, input logic [4:0] cmpId);
    w_claim       = clm;
    w_claim_id    = clmId;
    w_complete    = cmp;
    w_complete_id = cmpId;
    tick(1);
    w_claim       = 1'b0;
    w_complete    = 1'b0;
  endtask

  // One-cycle high pulse on source 3; returns 1 edge after it was sampled
  task automatic pulse3();
    w_irq[3] = 1'b1;
    tick(1);
    w_irq[3] = 1'b0;
    tick(1);
  endtask

  // Pulse source 3 from IDLE and confirm it pends three edges after sampling
  task automatic pendEdge3(input string tag);
    pulse3();
    tick(2);
    checkOutput(tag, {31'b0, w_pending[3]}, 32'd1);
  endtask

  initial begin
    RST           = 1'b1;
    w_irq         = '0;
    w_claim       = 1'b0;
    w_claim_id    = '0;
    w_complete    = 1'b0;
    w_complete_id = '0;

    // Reset state
    tick(2);
    checkOutput("rst_pending", w_pending, 32'h0);
    checkOutput("rst_inflight", w_inflight, 32'h0);
    checkOutput("rst_overflow", {31'b0, w_overflow}, 32'h0);
    RST = 1'b0;
    tick(1);

    // Level source 5: latency, claim, complete while still high
    w_irq[5] = 1'b1;
    tick(3);
    checkOutput("lvl5_k2", w_pending, 32'h0);
    tick(1);
    checkOutput("lvl5_k3", w_pending, 32'h20);
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd0);
    checkOutput("lvl5_claim_pend", w_pending, 32'h0);
    checkOutput("lvl5_claim_infl", w_inflight, 32'h20);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd5);
    checkOutput("lvl5_cmp_pend", w_pending, 32'h0);
    checkOutput("lvl5_cmp_infl", w_inflight, 32'h0);
    tick(1);
    checkOutput("lvl5_repend", w_pending, 32'h20);
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd0);
    w_irq[5] = 1'b0;
    tick(4);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd5);
    tick(2);
    checkOutput("lvl5_idle_pend", w_pending, 32'h0);
    checkOutput("lvl5_idle_infl", w_inflight, 32'h0);

    // Ignored claims and completes
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7);
    checkOutput("ign_pending", w_pending, 32'h0);
    checkOutput("ign_inflight", w_inflight, 32'h0);
    checkOutput("ign_overflow", {31'b0, w_overflow}, 32'h0);

    // Edge source 3: three edges while CLAIMED replay three times
    pendEdge3("e3_pend");
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    checkOutput("e3_claim", w_inflight, 32'h8);
    repeat (3) pulse3();
    tick(3);
    checkOutput("e3_hold_infl", w_inflight, 32'h8);
    checkOutput("e3_hold_pend", w_pending, 32'h0);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
      checkOutput("e3_replay_pend", w_pending, 32'h8);
      applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
      checkOutput("e3_replay_infl", w_inflight, 32'h8);
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
    checkOutput("e3_final_pend", w_pending, 32'h0);
    checkOutput("e3_final_infl", w_inflight, 32'h0);

    // Edge source 3: saturation after 9 edges, two overflow pulses
    pendEdge3("sat_pend");
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    checkOutput("sat_claim", w_inflight, 32'h8);
    repeat (9) pulse3();
    tick(3);
    checkOutput("sat_ovf_pulses", ovfPulses, 32'd2);
    for (int r = 0; r < 7; r++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
      checkOutput("sat_replay_pend", w_pending, 32'h8);
      applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
      checkOutput("sat_replay_infl", w_inflight, 32'h8);
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
    checkOutput("sat_final_pend", w_pending, 32'h0);
    checkOutput("sat_final_infl", w_inflight, 32'h0);

    // Edge and complete on source 3 in the same cycle with count 0
    pendEdge3("same_pend");
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    w_irq[3] = 1'b1;
    tick(1);
    w_irq[3] = 1'b0;
    tick(2);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
    checkOutput("same_repend", w_pending, 32'h8);
    checkOutput("same_infl", w_inflight, 32'h0);
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
    checkOutput("same_cnt0_pend", w_pending, 32'h0);
    checkOutput("same_cnt0_infl", w_inflight, 32'h0);

    // Claim and complete of the same ID in one cycle
    pendEdge3("cc_pend");
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3);
    checkOutput("cc_claimed", w_inflight, 32'h8);
    checkOutput("cc_claimed_pend", w_pending, 32'h0);
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3);
    checkOutput("cc_done_infl", w_inflight, 32'h0);
    checkOutput("cc_done_pend", w_pending, 32'h0);

    // Mid-operation reset discards pending, claimed and counted requests
    w_irq[2] = 1'b1;
    w_irq[4] = 1'b1;
    pendEdge3("mid_pend3");
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    repeat (2) pulse3();
    tick(3);
    checkOutput("mid_pending", w_pending, 32'h14);
    checkOutput("mid_inflight", w_inflight, 32'h8);
    RST   = 1'b1;
    w_irq = '0;
    tick(1);
    checkOutput("mid_rst_pend", w_pending, 32'h0);
    checkOutput("mid_rst_infl", w_inflight, 32'h0);
    checkOutput("mid_rst_ovf", {31'b0, w_overflow}, 32'h0);
    RST = 1'b0;
    pendEdge3("post_pend3");
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3);
    tick(4);
    checkOutput("post_cnt_pend", w_pending, 32'h0);
    checkOutput("post_cnt_infl", w_inflight, 32'h0);

    // Level source held high across reset release
    RST      = 1'b1;
    w_irq[2] = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(3);
    checkOutput("rel_k2", w_pending, 32'h0);
    tick(1);
    checkOutput("rel_k3", w_pending, 32'h4);

    checkOutput("ovf_total", ovfPulses, 32'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
